sample_buffer_ctrl: RTL
=======================

# sample_buffer_ctrl

Circular-buffer controller that owns the single shared port of the on-chip `Memory` sample store, whose read is combinational and whose write is sequential over a tri-state data bus. It sits between the ADC acquisition path (writer) and the host readout path (reader). It arbitrates one memory access per cycle between them. It generates `addr`/`we`/`re`, drives the bus for writes, and tracks occupancy, full, empty and overflow.

## Interface
- `AW`, default 4, memory address width; depth is 2^AW.
- `DW`, default 8, sample/data width.

- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush of pointers, count and overflow.
- `wr_valid`  in  1  writer has a sample on `wr_data`.
- `wr_data`  in  DW  sample to store.
- `wr_ready`  out  1  write granted this cycle (combinational).
- `rd_req`  in  1  reader requests one word per granted cycle (level).
- `rd_valid`  out  1  `rd_data` valid; one-cycle pulse per popped word.
- `rd_data`  out  DW  registered read word.
- `mem_addr`  out  AW  memory address.
- `mem_we`  out  1  memory write enable.
- `mem_re`  out  1  memory read/output enable.
- `mem_data`  inout  DW  tri-state memory data bus.
- `count`  out  AW+1  words stored, range 0..2^AW.
- `full`, `empty`  out  1  `count == 2^AW` and `count == 0`.
- `overflow`  out  1  sticky: a write was attempted while full.

## Operation
- Registers:
  - `wptr` and `rptr`, AW bits each; both wrap modulo 2^AW naturally.
  - `count`, AW+1 bits.
  - `overflow`.
  - `last`, the last-grant state: IDLE, WRITE or READ.
  - `rd_data` and `rd_valid`.
- Eligibility (combinational): `weli = wr_valid & ~full & ~clear`; `reli = rd_req & ~empty & ~clear`.
- Grant (combinational, at most one per cycle):
  - Only `weli` is true: grant write.
  - Only `reli` is true: grant read.
  - Both are true and `last == WRITE`: grant read; otherwise grant write. After reset (`last == IDLE`), write wins.
- Write grant:
  - `wr_ready = 1`, `mem_we = 1`, `mem_addr = wptr`, `mem_data` driven with `wr_data`.
  - At posedge: memory stores the word, `wptr += 1`, `count += 1`, `last <= WRITE`.
- Read grant:
  - `mem_re = 1`, `mem_addr = rptr`, `mem_data` released to Z (memory drives it).
  - At posedge: `rd_data <= mem_data`, `rd_valid <= 1`, `rptr += 1`, `count -= 1`, `last <= READ`.
- No grant:
  - `mem_we = mem_re = 0`, `mem_data` = Z, `mem_addr = rptr`.
  - At posedge: `rd_valid <= 0`, `last` holds.
- The bus is never driven by both the controller and the memory. `mem_we` and `mem_re` are never both 1.
- Overflow: `wr_valid & full` at a posedge (without `clear`) sets `overflow`. It stays set until `clear` or `reset`.
- Reads while empty are ignored: no grant, `rd_valid` stays 0, no error flag.
- `clear`:
  - Takes priority over all requests; no grant in that cycle.
  - At posedge: `wptr`, `rptr`, `count`, `overflow`, `rd_valid` go to 0 and `last` goes to IDLE.
  - `rd_data` holds. Memory contents are not cleared.

## Timing
- Reset values (asynchronous, immediate on `reset` rise):
  - `wptr = rptr = 0`, `count = 0`, `last = IDLE`, `overflow = 0`, `rd_valid = 0`, `rd_data = 0`.
  - Hence `empty = 1`, `full = 0`, `wr_ready = 0`, `mem_we = mem_re = 0`, `mem_data` = Z.
- Reset mid-operation: any in-flight grant is dropped in the same cycle. Memory contents are undefined only if reset falls coincident with a write posedge.
- Write latency: a sample accepted in cycle N is readable (eligible for grant) in cycle N+1.
- Read latency: a read granted in cycle N gives `rd_valid = 1` with data in cycle N+1.
- Throughput: one access per cycle total. Under sustained contention, writes and reads alternate and `count` oscillates ±1.
- Boundary cases:
  - Full with `rd_req` and `wr_valid` both high: read granted, write refused (overflow set). Write eligible the next cycle.
  - Empty with both high: write granted, read refused.

## Test plan
- Reset: pulse `reset` with `wr_valid = rd_req = 1` -> all outputs at reset values immediately, `mem_data` = Z, `count = 0`, `empty = 1`.
- Fill (AW = 2): write 0x11, 0x22, 0x33, 0x44 back-to-back -> `wr_ready` high 4 cycles, `count = 4`, `full = 1`. Fifth write 0x55 -> `wr_ready = 0`, `overflow = 1` next cycle and stays set.
- Drain: from full, hold `rd_req` 5 cycles -> `rd_valid` pulses 4 cycles carrying 0x11, 0x22, 0x33, 0x44, each one cycle after its grant. Then `empty = 1`, no 5th `rd_valid`.
- Contention: `count = 2`, `last = IDLE`, hold `wr_valid` and `rd_req` -> grants W, R, W, R; `count` goes 3, 2, 3, 2; read data in FIFO order.
- Wrap: AW = 2, write 0xA0..0xA5 interleaved with reads -> pointers wrap past 3, read order 0xA0..0xA5 exact.
- Clear/reset mid-op: assert `clear` with `count = 3` and `overflow = 1` -> no grant that cycle, then `count = 0`, `overflow = 0`. Assert `reset` during a write grant -> `mem_we = 0` and `mem_data` = Z in the same cycle.

Source files
------------

// File: rtl/sample_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// sample_buffer_ctrl
//
// Circular-buffer controller that owns the single shared port of the on-chip
// sample store. The ADC writer and the host reader compete for that port, and
// this block grants at most one of them per cycle. It also tracks occupancy,
// full/empty and a sticky overflow flag. The memory reads combinationally
// (while mem_re is high) and writes on the clock edge (while mem_we is high).
// Both directions share one tri-state bus.
//
// Ports
//   clock     : sole clock, all state updates on posedge
//   reset     : asynchronous active-high reset
//   clear     : synchronous flush of pointers, count, overflow
//   wr_valid  : writer presents a sample on wr_data
//   wr_data   : sample to store
//   wr_ready  : write granted this cycle (combinational)
//   rd_req    : reader requests one word per granted cycle (level)
//   rd_valid  : one-cycle pulse, rd_data holds a freshly popped word
//   rd_data   : registered read word
//   mem_addr  : memory address
//   mem_we    : memory write enable
//   mem_re    : memory read / output enable
//   mem_data  : tri-state memory data bus
//   count     : stored words, 0..2^AW
//   full      : count == 2^AW
//   empty     : count == 0
//   overflow  : sticky, a write was attempted while full
// -----------------------------------------------------------------------------
module sample_buffer_ctrl #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_req,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    inout  tri   [DW-1:0] mem_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    // Occupancy value that means "every slot holds a word".
    localparam logic [AW:0] COUNT_FULL = {1'b1, {AW{1'b0}}};

    // Last-grant state. It is used only to break ties between the two sides.
    typedef enum logic [1:0] {
        LAST_IDLE  = 2'd0,
        LAST_WRITE = 2'd1,
        LAST_READ  = 2'd2
    } last_t;

    last_t         last_q,     last_d;
    logic [AW-1:0] wptr_q,     wptr_d;
    logic [AW-1:0] rptr_q,     rptr_d;
    logic [AW:0]   count_q,    count_d;
    logic          overflow_q, overflow_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q,  rd_data_d;

    logic w_eli;
    logic r_eli;
    logic grant_wr;
    logic grant_rd;

    assign full  = (count_q == COUNT_FULL);
    assign empty = (count_q == '0);

    // Arbitration and next-state logic.
    always_comb begin
        // The reset term drops any grant while reset is high. Without it,
        // the registers reset to empty and a pending wr_valid would be
        // granted before reset is released.
        w_eli      = wr_valid & ~full  & ~clear & ~reset;
        r_eli      = rd_req   & ~empty & ~clear & ~reset;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        last_d     = last_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        if (w_eli && r_eli) begin
            // Under contention, the read wins only if the previous grant was
            // a write. This makes sustained traffic alternate.
            if (last_q == LAST_WRITE) begin
                grant_rd = 1'b1;
            end else begin
                grant_wr = 1'b1;
            end
        end else if (w_eli) begin
            grant_wr = 1'b1;
        end else if (r_eli) begin
            grant_rd = 1'b1;
        end

        if (clear) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            last_d     = LAST_IDLE;
        end else begin
            // A write refused because the buffer is full is flagged, even
            // when a read is granted in the same cycle.
            if (wr_valid && full) begin
                overflow_d = 1'b1;
            end
            if (grant_wr) begin
                wptr_d  = wptr_q + 1'b1;
                count_d = count_q + 1'b1;
                last_d  = LAST_WRITE;
            end
            if (grant_rd) begin
                rptr_d     = rptr_q + 1'b1;
                count_d    = count_q - 1'b1;
                rd_valid_d = 1'b1;
                rd_data_d  = mem_data;
                last_d     = LAST_READ;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q     <= LAST_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            last_q     <= last_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign wr_ready = grant_wr;
    assign mem_we   = grant_wr;
    assign mem_re   = grant_rd;
    // Idle cycles park the address on the read pointer.
    assign mem_addr = grant_wr ? wptr_q : rptr_q;
    // The controller drives the bus only during a write grant. The memory
    // drives it only while mem_re is high. The two grants are exclusive.
    assign mem_data = grant_wr ? wr_data : {DW{1'bz}};

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
